mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: issues one handshake per
// load/store, stalls the pipeline until ack (or timeout), aligns store
// lanes and extends load data.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // Counter holds the index of the current BUSY cycle (0 .. ACK_TIMEOUT-1).
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             buserr_q, buserr_d;
  logic             stall_c, misalign_c;

  logic is_store, is_load, is_access, misaligned;

  // Size code funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data so every enabled lane sees it.
  function automatic logic [31:0] store_data_f(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend_f(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rd >> {a, 3'b000};
    b = shifted[7:0];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  assign is_store   = MemWriteM;
  assign is_load    = !MemWriteM && (ResultSrcM == 2'b01);
  assign is_access  = is_store || is_load;
  assign misaligned = misaligned_f(funct3M[1:0], ALUResultM[1:0]);

  // Next-state, handshake register and combinational stall/misalign decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    rdata_d    = rdata_q;
    buserr_d   = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_access) begin
          if (misaligned) begin
            misalign_c = 1'b1;
            rdata_d    = 32'd0;
          end else begin
            stall_c = 1'b1;
            state_d = BUSY;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_store;
            be_d    = lane_mask_f(funct3M[1:0], ALUResultM[1:0]);
            addr_d  = {ALUResultM[31:2], 2'b00};
            wdata_d = is_store ? store_data_f(funct3M[1:0], WriteDataM) : 32'd0;
            f3_d    = funct3M;
            lane_d  = ALUResultM[1:0];
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          state_d = HOLD;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          if (!we_q) rdata_d = load_extend_f(f3_q, lane_q, mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HOLD;
          req_d    = 1'b0;
          we_d     = 1'b0;
          be_d     = 4'b0000;
          buserr_d = 1'b1;
          rdata_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        be_d    = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset clears everything and abandons any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      lane_q   <= 2'd0;
      rdata_q  <= 32'd0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  assign StallM    = stall_c && !rst;
  assign MisalignM = misalign_c && !rst;
  assign ReadDataM = rdata_q;
  assign BusErrM   = buserr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores against a byte-level reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, mem_rdata;
  logic        MemWriteM, mem_ack;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic        StallM, MisalignM, BusErrM, mem_req, mem_we;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_rd = 32'd0;

  mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes, lanes and data from plain arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    return 4'(((1 << nbytes(f3)) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % nbytes(f3)))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [63:0] v;
    int n;
    n = nbytes(f3);
    v = ({32'd0, rd} >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 64'd1);
    if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1)
      v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // One instruction through the MEM stage, acting as both pipeline and memory.
  // ack_dly = BUSY cycle index of the ack; ack_dly >= TO means no ack (timeout).
  task automatic run_access(input logic st, input logic [1:0] rs, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_dly);
    logic ld, acc, mis, timed_out;
    ld  = !st && rs == 2'b01;
    acc = st || ld;
    mis = acc && ((addr % 4) % nbytes(f3) != 0);
    step();
    ALUResultM = addr; WriteDataM = wd; MemWriteM = st; ResultSrcM = rs; funct3M = f3;
    mem_ack = 1'($urandom_range(1)); mem_rdata = $urandom;
    @(negedge clk);
    check("idle_stall", 32'(StallM), 32'(acc && !mis));
    check("idle_misalign", 32'(MisalignM), 32'(mis));
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_be", 32'(mem_be), 32'd0);
    check("idle_rdata_hold", ReadDataM, exp_rd);
    if (!acc || mis) begin
      if (mis) exp_rd = 32'd0;
      return;
    end
    timed_out = 1'b1;
    for (int k = 0; k < TO; k++) begin
      step();
      mem_ack   = (k == ack_dly);
      mem_rdata = (k == ack_dly) ? rd : $urandom;
      @(negedge clk);
      check("busy_stall", 32'(StallM), 32'd1);
      check("busy_req", 32'(mem_req), 32'd1);
      check("busy_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("busy_we", 32'(mem_we), 32'(st));
      check("busy_be", 32'(mem_be), 32'(model_be(f3, addr)));
      if (st) check("busy_wdata", mem_wdata, model_wdata(f3, wd));
      check("busy_buserr", 32'(BusErrM), 32'd0);
      if (k == ack_dly) begin
        timed_out = 1'b0;
        break;
      end
    end
    step();
    mem_ack = 1'($urandom_range(1)); mem_rdata = $urandom;
    if (timed_out) exp_rd = 32'd0;
    else if (ld) exp_rd = model_load(f3, addr, rd);
    @(negedge clk);
    check("hold_stall", 32'(StallM), 32'd0);
    check("hold_req", 32'(mem_req), 32'd0);
    check("hold_we", 32'(mem_we), 32'd0);
    check("hold_be", 32'(mem_be), 32'd0);
    check("hold_buserr", 32'(BusErrM), 32'(timed_out));
    check("hold_rdata", ReadDataM, exp_rd);
  endtask

  task automatic idle_inputs();
    MemWriteM = 1'b0; ResultSrcM = 2'b00; funct3M = 3'b000;
    ALUResultM = 32'd0; WriteDataM = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  initial begin
    logic [2:0] ld_codes [5];
    logic       st;
    logic [1:0] rs;
    logic [2:0] f3;
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    step(); step();
    @(negedge clk);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_buserr", 32'(BusErrM), 32'd0);
    check("rst_misalign", 32'(MisalignM), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_access(1'b0, 2'b01, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    check("lw_value", ReadDataM, 32'hDEADBEEF);
    run_access(1'b0, 2'b01, 3'b000, 32'h103, 32'd0, 32'h80FFFFFF, 1);
    check("lb_value", ReadDataM, 32'hFFFFFF80);
    run_access(1'b0, 2'b01, 3'b100, 32'h103, 32'd0, 32'h80FFFFFF, 0);
    check("lbu_value", ReadDataM, 32'h00000080);
    run_access(1'b1, 2'b00, 3'b001, 32'h202, 32'h1234ABCD, 32'd0, 2);
    run_access(1'b0, 2'b01, 3'b010, 32'h101, 32'd0, 32'h0, 0);
    run_access(1'b0, 2'b00, 3'b010, 32'h400, 32'd0, 32'h0, 0);
    run_access(1'b0, 2'b01, 3'b101, 32'h302, 32'd0, 32'h8001_7FFF, 0);
    check("lhu_value", ReadDataM, 32'h00008001);
    run_access(1'b0, 2'b01, 3'b010, 32'h500, 32'd0, 32'h1111_2222, TO);
    check("timeout_rdata", ReadDataM, 32'd0);
    run_access(1'b1, 2'b01, 3'b000, 32'h601, 32'h0000_00A5, 32'd0, 0);
    run_access(1'b1, 2'b00, 3'b010, 32'h602, 32'h5555_AAAA, 32'd0, 0);
    run_access(1'b0, 2'b01, 3'b001, 32'h700, 32'd0, 32'h0000_8123, 3);
    check("lh_value", ReadDataM, 32'hFFFF8123);

    // Reset in the second BUSY cycle, ack arriving one cycle later
    step();
    ALUResultM = 32'h800; MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rb_idle_stall", 32'(StallM), 32'd1);
    step();
    @(negedge clk);
    check("rb_busy_req", 32'(mem_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    exp_rd = 32'd0;
    @(negedge clk);
    check("rb_req", 32'(mem_req), 32'd0);
    check("rb_stall", 32'(StallM), 32'd0);
    check("rb_rdata", ReadDataM, 32'd0);
    check("rb_buserr", 32'(BusErrM), 32'd0);
    check("rb_be", 32'(mem_be), 32'd0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("rb_late_ack_rdata", ReadDataM, 32'd0);
    check("rb_late_ack_req", 32'(mem_req), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = int'($urandom_range(7));
      if (kind == 0) begin
        st = 1'b0; rs = 2'($urandom_range(1)) << 1;
        f3 = ld_codes[$urandom_range(4)];
      end else if (kind <= 3) begin
        st = 1'b0; rs = 2'b01;
        f3 = ld_codes[$urandom_range(4)];
      end else begin
        st = 1'b1; rs = 2'($urandom_range(2));
        f3 = 3'($urandom_range(2));
      end
      run_access(st, rs, f3, $urandom, $urandom, $urandom, int'($urandom_range(TO)));
    end

    step();
    idle_inputs();
    @(negedge clk);
    check("end_rdata_hold", ReadDataM, exp_rd);
    check("end_req", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
